// File: rtl/core_pkg.sv
// Shared types and constants for the multicycle core front end.
// Holds the fetch FSM states, branch condition codes and PC step.
package core_pkg;

  typedef enum logic [1:0] {
    ST_FETCH   = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_RESOLVE = 2'd2,
    ST_HALTED  = 2'd3
  } state_t;

  localparam logic [2:0] COND_NEVER  = 3'd0;
  localparam logic [2:0] COND_ALWAYS = 3'd1;
  localparam logic [2:0] COND_LT     = 3'd2;
  localparam logic [2:0] COND_EQ     = 3'd3;
  localparam logic [2:0] COND_GT     = 3'd4;

  localparam logic [31:0] PC_STEP = 32'd4;

endpackage

// File: rtl/branch_cond_eval.sv
// Branch condition evaluation: signed compare of br_a against zero,
// selected by the condition code. Codes 5..7 never take.
module branch_cond_eval
  import core_pkg::*;
(
  input  logic [31:0] br_a,
  input  logic [2:0]  br_cond,
  output logic        cond_true
);

  logic w_neg;
  logic w_zero;

  assign w_neg  = $signed(br_a) < $signed(32'sd0);
  assign w_zero = (br_a == 32'd0);

  always_comb begin
    cond_true = 1'b0;
    unique case (br_cond)
      COND_ALWAYS: cond_true = 1'b1;
      COND_LT:     cond_true = w_neg;
      COND_EQ:     cond_true = w_zero;
      COND_GT:     cond_true = !w_neg && !w_zero;
      default:     cond_true = 1'b0;
    endcase
  end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// PC and fetch controller: fetch over req/ack, issue over valid/ready,
// then wait for the branch resolution and load the next PC.
module pc_fetch_ctrl
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        br_valid,
  input  logic [2:0]  br_cond,
  input  logic [31:0] br_a,
  input  logic [31:0] br_target,
  input  logic        halt,
  output logic [31:0] pc,
  output logic [31:0] npc,
  output logic        taken,
  output logic        halted
);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] w_pc_nxt;
  logic [31:0] r_instr;
  logic [31:0] w_instr_nxt;
  logic        r_taken;
  logic        w_taken_nxt;
  logic [31:0] w_npc;
  logic [31:0] w_redirect;
  logic        w_cond_true;
  logic        w_unused_tgt;

  branch_cond_eval u_cond (
    .br_a      (br_a),
    .br_cond   (br_cond),
    .cond_true (w_cond_true)
  );

  assign w_npc        = r_pc + PC_STEP;
  assign w_redirect   = {br_target[31:2], 2'b00};
  assign w_unused_tgt = ^br_target[1:0];

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_instr_nxt = r_instr;
    w_taken_nxt = 1'b0;
    unique case (r_state)
      ST_FETCH: begin
        if (imem_ack) begin
          w_state_nxt = ST_ISSUE;
          w_instr_nxt = imem_rdata;
        end
      end
      ST_ISSUE: begin
        if (instr_ready) w_state_nxt = ST_RESOLVE;
      end
      ST_RESOLVE: begin
        if (br_valid) begin
          w_state_nxt = halt ? ST_HALTED : ST_FETCH;
          w_pc_nxt    = w_cond_true ? w_redirect : w_npc;
          w_taken_nxt = w_cond_true;
        end
      end
      ST_HALTED: begin
        w_state_nxt = ST_HALTED;
      end
      default: begin
        w_state_nxt = ST_FETCH;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_FETCH;
      r_pc    <= RESET_PC;
      r_instr <= 32'd0;
      r_taken <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_instr <= w_instr_nxt;
      r_taken <= w_taken_nxt;
    end
  end

  assign imem_req    = (r_state == ST_FETCH);
  assign imem_addr   = r_pc;
  assign instr       = r_instr;
  assign instr_valid = (r_state == ST_ISSUE);
  assign halted      = (r_state == ST_HALTED);
  assign pc          = r_pc;
  assign npc         = w_npc;
  assign taken       = r_taken;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Bench for pc_fetch_ctrl: scoreboard queues of expected fetch
// addresses and instruction words, one task per scenario.
module tb_pc_fetch_ctrl;

  localparam logic [31:0] RPC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic        br_valid;
  logic [2:0]  br_cond;
  logic [31:0] br_a;
  logic [31:0] br_target;
  logic        halt;
  logic [31:0] pc;
  logic [31:0] npc;
  logic        taken;
  logic        halted;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp_addr[$];
  logic [31:0] exp_instr[$];
  logic [31:0] m_pc;

  pc_fetch_ctrl #(.RESET_PC(RPC)) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .br_valid    (br_valid),
    .br_cond     (br_cond),
    .br_a        (br_a),
    .br_target   (br_target),
    .halt        (halt),
    .pc          (pc),
    .npc         (npc),
    .taken       (taken),
    .halted      (halted)
  );

  always #5 clk = ~clk;

  function automatic logic ref_cond(input logic [2:0] c,
                                    input logic [31:0] a);
    case (c)
      3'd1:    return 1'b1;
      3'd2:    return $signed(a) < 0;
      3'd3:    return a == 32'd0;
      3'd4:    return $signed(a) > 0;
      default: return 1'b0;
    endcase
  endfunction

  task automatic do_reset;
    @(negedge clk);
    rst = 1'b1;
    imem_ack = 1'b0;
    instr_ready = 1'b0;
    br_valid = 1'b0;
    halt = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    exp_addr.delete();
    exp_instr.delete();
    exp_addr.push_back(RPC);
    m_pc = RPC;
  endtask

  // One full fetch/issue/resolve loop with optional waits and
  // spurious pulses in the states where they must be ignored.
  task automatic one_instr(input logic [31:0] data,
                           input int ack_dly, input int rdy_dly,
                           input int res_dly,
                           input logic [2:0] c, input logic [31:0] a,
                           input logic [31:0] tgt, input logic hlt,
                           output int cyc);
    logic [31:0] e;
    logic [31:0] nx;
    logic        ct;
    int          w;
    cyc = 0;
    w = 0;
    while (!imem_req && w < 20) begin
      @(negedge clk);
      w++;
    end
    n_vec++;
    if (imem_req !== 1'b1) begin
      $display("FAIL req_timeout: imem_req=%b want 1", imem_req);
      n_err++;
      return;
    end
    e = (exp_addr.size() > 0) ? exp_addr.pop_front() : 32'hxxxx_xxxx;
    n_vec++;
    if (imem_addr !== e) begin
      $display("FAIL fetch_addr: got %h want %h", imem_addr, e);
      n_err++;
    end
    imem_rdata = ~data;
    for (int i = 0; i < ack_dly; i++) begin
      br_valid = (i == 1);
      halt = (i == 1);
      br_cond = 3'd1;
      br_target = 32'hDEAD_BEEF;
      @(negedge clk);
      cyc++;
      n_vec++;
      if (imem_req !== 1'b1 || instr_valid !== 1'b0 || pc !== m_pc) begin
        $display("FAIL fetch_wait: req=%b vld=%b pc=%h want 1 0 %h",
                 imem_req, instr_valid, pc, m_pc);
        n_err++;
      end
    end
    br_valid = 1'b0;
    halt = 1'b0;
    imem_ack = 1'b1;
    imem_rdata = data;
    exp_instr.push_back(data);
    @(negedge clk);
    cyc++;
    imem_ack = 1'b0;
    imem_rdata = ~data;
    e = exp_instr.pop_front();
    n_vec++;
    if (instr_valid !== 1'b1 || instr !== e) begin
      $display("FAIL issue: vld=%b instr=%h want 1 %h",
               instr_valid, instr, e);
      n_err++;
    end
    n_vec++;
    if (taken !== 1'b0) begin
      $display("FAIL taken_pulse: got %b want 0", taken);
      n_err++;
    end
    for (int i = 0; i < rdy_dly; i++) begin
      imem_ack = (i == 0);
      br_valid = (i == 1);
      @(negedge clk);
      cyc++;
      n_vec++;
      if (instr_valid !== 1'b1 || instr !== data || imem_req !== 1'b0) begin
        $display("FAIL issue_wait: vld=%b instr=%h req=%b want 1 %h 0",
                 instr_valid, instr, imem_req, data);
        n_err++;
      end
    end
    imem_ack = 1'b0;
    br_valid = 1'b0;
    instr_ready = 1'b1;
    @(negedge clk);
    cyc++;
    instr_ready = 1'b0;
    n_vec++;
    if (instr_valid !== 1'b0 || imem_req !== 1'b0 || instr !== data) begin
      $display("FAIL handshake: vld=%b req=%b instr=%h want 0 0 %h",
               instr_valid, imem_req, instr, data);
      n_err++;
    end
    for (int i = 0; i < res_dly; i++) begin
      imem_ack = (i == 0);
      instr_ready = (i == 1);
      halt = 1'b1;
      @(negedge clk);
      cyc++;
      n_vec++;
      if (imem_req !== 1'b0 || pc !== m_pc || instr !== data ||
          halted !== 1'b0) begin
        $display("FAIL resolve_wait: req=%b pc=%h instr=%h hlt=%b",
                 imem_req, pc, instr, halted);
        n_err++;
      end
    end
    imem_ack = 1'b0;
    instr_ready = 1'b0;
    br_valid = 1'b1;
    br_cond = c;
    br_a = a;
    br_target = tgt;
    halt = hlt;
    ct = ref_cond(c, a);
    nx = ct ? {tgt[31:2], 2'b00} : m_pc + 32'd4;
    if (!hlt) exp_addr.push_back(nx);
    @(negedge clk);
    cyc++;
    br_valid = 1'b0;
    halt = 1'b0;
    n_vec++;
    if (pc !== nx || npc !== nx + 32'd4 || taken !== ct) begin
      $display("FAIL resolve: pc=%h npc=%h tk=%b want %h %h %b",
               pc, npc, taken, nx, nx + 32'd4, ct);
      n_err++;
    end
    n_vec++;
    if (halted !== hlt || imem_req !== !hlt) begin
      $display("FAIL after_resolve: halted=%b req=%b want %b %b",
               halted, imem_req, hlt, !hlt);
      n_err++;
    end
    m_pc = nx;
  endtask

  task automatic test_reset;
    do_reset();
    n_vec++;
    if (pc !== RPC || instr !== 32'd0 || instr_valid !== 1'b0 ||
        taken !== 1'b0 || halted !== 1'b0) begin
      $display("FAIL reset_vals: pc=%h instr=%h vld=%b tk=%b hlt=%b",
               pc, instr, instr_valid, taken, halted);
      n_err++;
    end
    n_vec++;
    if (imem_req !== 1'b1 || imem_addr !== RPC || npc !== RPC + 32'd4) begin
      $display("FAIL reset_req: req=%b addr=%h npc=%h want 1 %h %h",
               imem_req, imem_addr, npc, RPC, RPC + 32'd4);
      n_err++;
    end
  endtask

  task automatic test_straight;
    int cyc;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      one_instr(32'h0000_0013 + (k << 7), 0, 0, 0, 3'd0, 32'd0,
                32'h0000_0ABC, 1'b0, cyc);
      n_vec++;
      if (cyc !== 3) begin
        $display("FAIL loop_cycles: got %0d want 3", cyc);
        n_err++;
      end
      n_vec++;
      if (pc !== 32'(4 * (k + 1))) begin
        $display("FAIL straight_pc: got %h want %h", pc, 32'(4 * (k + 1)));
        n_err++;
      end
    end
  endtask

  typedef struct {
    logic [2:0]  c;
    logic [31:0] a;
    logic [31:0] pc_exp;
  } cond_vec_t;

  task automatic test_conditions;
    cond_vec_t tbl[12];
    int cyc;
    tbl[0]  = '{3'd2, 32'hFFFF_FFFF, 32'h0000_0100};
    tbl[1]  = '{3'd3, 32'hFFFF_FFFF, 32'h0000_0104};
    tbl[2]  = '{3'd4, 32'hFFFF_FFFF, 32'h0000_0108};
    tbl[3]  = '{3'd3, 32'h0000_0000, 32'h0000_0100};
    tbl[4]  = '{3'd6, 32'h0000_0000, 32'h0000_0104};
    tbl[5]  = '{3'd1, 32'h0000_0005, 32'h0000_0100};
    tbl[6]  = '{3'd4, 32'h0000_0001, 32'h0000_0100};
    tbl[7]  = '{3'd2, 32'h8000_0000, 32'h0000_0100};
    tbl[8]  = '{3'd4, 32'h8000_0000, 32'h0000_0104};
    tbl[9]  = '{3'd0, 32'h0000_0000, 32'h0000_0108};
    tbl[10] = '{3'd5, 32'h0000_0000, 32'h0000_010C};
    tbl[11] = '{3'd7, 32'h0000_0000, 32'h0000_0110};
    for (int i = 0; i < 12; i++) begin
      one_instr(32'h1000_0000 + i, 0, 0, 0, tbl[i].c, tbl[i].a,
                32'h0000_0103, 1'b0, cyc);
      n_vec++;
      if (pc !== tbl[i].pc_exp) begin
        $display("FAIL cond_%0d: pc=%h want %h", i, pc, tbl[i].pc_exp);
        n_err++;
      end
    end
  endtask

  task automatic test_backpressure;
    int cyc;
    one_instr(32'hA5A5_5A5A, 5, 4, 2, 3'd0, 32'd0, 32'h0, 1'b0, cyc);
    n_vec++;
    if (cyc !== 14) begin
      $display("FAIL bp_cycles: got %0d want 14", cyc);
      n_err++;
    end
    one_instr(32'h5A5A_A5A5, 2, 1, 1, 3'd1, 32'd0, 32'h0000_0040,
              1'b0, cyc);
  endtask

  task automatic test_wrap;
    int cyc;
    one_instr(32'h0000_0001, 0, 0, 0, 3'd1, 32'd0, 32'hFFFF_FFFF,
              1'b0, cyc);
    n_vec++;
    if (pc !== 32'hFFFF_FFFC || npc !== 32'h0) begin
      $display("FAIL wrap_npc: pc=%h npc=%h want fffffffc 0", pc, npc);
      n_err++;
    end
    one_instr(32'h0000_0002, 0, 0, 0, 3'd0, 32'd0, 32'h0, 1'b0, cyc);
    n_vec++;
    if (imem_addr !== 32'h0 || imem_req !== 1'b1) begin
      $display("FAIL wrap_addr: addr=%h req=%b want 0 1",
               imem_addr, imem_req);
      n_err++;
    end
    one_instr(32'h0000_0003, 0, 0, 0, 3'd0, 32'd0, 32'h0, 1'b0, cyc);
  endtask

  task automatic test_halt_reset;
    int cyc;
    one_instr(32'h0000_0073, 1, 0, 0, 3'd1, 32'd0, 32'h0000_0201,
              1'b1, cyc);
    n_vec++;
    if (halted !== 1'b1 || pc !== 32'h0000_0200) begin
      $display("FAIL halt_state: halted=%b pc=%h want 1 00000200",
               halted, pc);
      n_err++;
    end
    for (int i = 0; i < 5; i++) begin
      br_valid = (i == 1);
      imem_ack = (i == 2);
      instr_ready = (i == 3);
      @(negedge clk);
      n_vec++;
      if (imem_req !== 1'b0 || halted !== 1'b1 || pc !== 32'h0000_0200 ||
          taken !== 1'b0) begin
        $display("FAIL halt_hold: req=%b hlt=%b pc=%h tk=%b",
                 imem_req, halted, pc, taken);
        n_err++;
      end
    end
    br_valid = 1'b0;
    imem_ack = 1'b0;
    instr_ready = 1'b0;
    do_reset();
    one_instr(32'h0000_0011, 0, 0, 0, 3'd0, 32'd0, 32'h0, 1'b0, cyc);
    rst = 1'b1;
    imem_ack = 1'b1;
    imem_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    rst = 1'b0;
    imem_ack = 1'b0;
    n_vec++;
    if (pc !== RPC || instr_valid !== 1'b0 || instr !== 32'd0 ||
        halted !== 1'b0) begin
      $display("FAIL rst_mid: pc=%h vld=%b instr=%h hlt=%b want %h 0 0 0",
               pc, instr_valid, instr, halted, RPC);
      n_err++;
    end
    n_vec++;
    if (imem_req !== 1'b1 || imem_addr !== RPC) begin
      $display("FAIL rst_refetch: req=%b addr=%h want 1 %h",
               imem_req, imem_addr, RPC);
      n_err++;
    end
    exp_addr.delete();
    exp_instr.delete();
    exp_addr.push_back(RPC);
    m_pc = RPC;
    one_instr(32'h0000_0022, 0, 0, 0, 3'd0, 32'd0, 32'h0, 1'b0, cyc);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    imem_ack = 1'b0;
    imem_rdata = 32'd0;
    instr_ready = 1'b0;
    br_valid = 1'b0;
    br_cond = 3'd0;
    br_a = 32'd0;
    br_target = 32'd0;
    halt = 1'b0;
    m_pc = RPC;
    test_reset();
    test_straight();
    test_conditions();
    test_backpressure();
    test_wrap();
    test_halt_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
